stream_demux4: RTL and testbench
================================

// Module: stream_demux4
// PURPOSE
//  1:4 registered stream demultiplexer, the distribution end of the 4:1 select mux.
//  Accepts one valid/ready input word plus a 2-bit destination select.
//  Delivers the word to one of four output channels, each through a one-entry holding slot.
//  Used where one producer fans out to four consumers that stall independently.
// PARAMETERS
//  WIDTH   1   data width of input and of each output channel
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_data    in   WIDTH  input word
//  in_sel     in   2      destination: 0->out1, 1->out2, 2->out3, 3->out4
//  in_valid   in   1      input word and in_sel valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  outN_data  out  WIDTH  channel N word, N=1..4
//  outN_valid out  1      channel N slot holds a word
//  outN_ready in   1      channel N consumer takes the word this cycle
//  in_rr      in   1      only with STREAM_DEMUX4_RR_EN: round-robin destination mode
// BEHAVIOUR
//  - Reset (rst=1 at edge): all outN_valid=0; all outN_data=0; rr pointer=0.
//    Takes priority over any in-flight transfer, and held words are discarded.
//  - Handshakes:
//    - Accept:   in_valid & in_ready. Drain N: outN_valid & outN_ready.
//    - dest = in_sel, or the rr pointer when round-robin mode is active.
//    - in_ready = ~slot_valid[dest] | outN_ready[dest], so in_ready depends combinationally on in_sel and outN_ready.
//    - in_ready does not depend on in_valid.
//  - Latency: a word accepted in cycle t appears on outN_data/outN_valid in cycle t+1.
//    Full throughput, one word per cycle, as long as each destination drains.
//  - Slot N update per edge, in priority order:
//    - accept to N: data<=in_data, valid<=1. This covers the simultaneous drain+refill case.
//    - else drain N: valid<=0, data held.
//    - else hold.
//  - Only the dest slot may load in a cycle. Other slots drain independently in the same cycle.
//  - Full slot with no drain: in_ready=0 for that dest only. Input words for other dests are still accepted.
//  - Once outN_valid=1, outN_data is stable until drained; no word is ever dropped or duplicated.
//  - No ordering guarantee across channels; per channel, order is preserved (depth 1).
// CONFIGURATION
//  - STREAM_DEMUX4_RR_EN defined:
//    - Adds port in_rr and a 2-bit rr pointer.
//    - When in_rr=1: dest=pointer and in_sel is ignored. On each accept, pointer<=pointer+1 (wraps 3->0).
//    - When in_rr=0: dest=in_sel and the pointer holds.
//  - Not defined: no in_rr port, no pointer; dest=in_sel always.
// STRUCTURE
//  - Package stream_demux4_pkg:
//    - localparam NUM_OUT=4
//    - typedef logic [1:0] dest_t
//    - function dest_t rr_next(dest_t), wraps 3->0
//  - Sub-module stream_slot #(WIDTH): one-entry valid/data holding register with load/drain. Instantiated 4x.
//  - Top level holds dest decode, in_ready mux and the optional rr pointer.
// TESTING
//  1. Reset: drive rst=1 with in_valid=1 -> all outN_valid=0, outN_data=0, and the next cycle shows no output.
//  2. Route: WIDTH=8, send 0xA1/sel0, 0xB2/sel1, 0xC3/sel2, 0xD4/sel3, all ready=1
//     -> each appears on out1..out4 one cycle after accept, in_ready held at 1.
//  3. Backpressure: out2_ready=0; send 0x11/sel1 then 0x22/sel1
//     -> out2_data=0x11 holds and in_ready=0 for the second word.
//     Raise out2_ready -> drain and load in the same edge, out2_data=0x22.
//  4. Independence: out3 full and stalled; send 0x55/sel0 -> accepted, out1_data=0x55, out3 unchanged.
//  5. Reset mid-operation: out1 and out4 full and stalled; rst=1 for one cycle
//     -> both valid=0, and the next accept routes normally.
//  6. RR (macro defined): in_rr=1, six words 0..5, in_sel=3 constant
//     -> destinations 1,2,3,4,1,2. Then in_rr=0 with sel=2 -> out3, and the pointer holds at 2.

Source files
------------

// File: rtl/stream_demux4_pkg.sv
// Shared types for the 1:4 stream demux: channel count, destination index, round-robin step.
// Latency: n/a (types only). Backpressure: n/a.
package stream_demux4_pkg;
  localparam int NUM_OUT = 4;

  typedef logic [1:0] dest_t;

  function automatic dest_t rr_next(input dest_t p);
    return p + 2'd1;
  endfunction
endpackage

// File: rtl/stream_demux4_if.sv
// Bundle of the demux input stream and its four output channels; in_rr exists only with STREAM_DEMUX4_RR_EN.
// Latency: n/a (wiring). Backpressure: in_ready / outN_ready carried here.
// The master side is the producer/consumers; the slave side is the demux itself.
interface stream_demux4_if #(parameter int WIDTH = 1);
  import stream_demux4_pkg::*;

  logic [WIDTH-1:0] in_data;
  dest_t            in_sel;
  logic             in_valid;
  logic             in_ready;
`ifdef STREAM_DEMUX4_RR_EN
  logic             in_rr;
`endif
  logic [WIDTH-1:0] out1_data, out2_data, out3_data, out4_data;
  logic             out1_valid, out2_valid, out3_valid, out4_valid;
  logic             out1_ready, out2_ready, out3_ready, out4_ready;

  modport master (
`ifdef STREAM_DEMUX4_RR_EN
    output in_rr,
`endif
    output in_data, in_sel, in_valid,
    input  in_ready,
    input  out1_data, out2_data, out3_data, out4_data,
    input  out1_valid, out2_valid, out3_valid, out4_valid,
    output out1_ready, out2_ready, out3_ready, out4_ready
  );

  modport slave (
`ifdef STREAM_DEMUX4_RR_EN
    input  in_rr,
`endif
    input  in_data, in_sel, in_valid,
    output in_ready,
    output out1_data, out2_data, out3_data, out4_data,
    output out1_valid, out2_valid, out3_valid, out4_valid,
    input  out1_ready, out2_ready, out3_ready, out4_ready
  );
endinterface

// File: rtl/stream_demux4_slot.sv
// One-entry holding register for a demux output channel; load wins over drain.
// Latency: loaded word visible the cycle after load. Backpressure: owner must only load when empty or draining.
module stream_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             slot_valid,
  output logic [WIDTH-1:0] slot_data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_data  <= load_data;
    end else if (drain) begin
      slot_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux4.sv
// 1:4 registered stream demux: routes each input word to one of four one-entry output slots (round-robin via STREAM_DEMUX4_RR_EN).
// Latency: 1 cycle input to output, full throughput. Backpressure: in_ready drops only when the selected slot is full and not draining.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input logic            clk,
  input logic            rst,
  stream_demux4_if.slave bus
);
  dest_t                dest;
  logic                 accept;
  logic [NUM_OUT-1:0]   slot_vld;
  logic [NUM_OUT-1:0]   out_rdy;
  logic [WIDTH-1:0]     slot_dat [NUM_OUT];

  assign out_rdy = {bus.out4_ready, bus.out3_ready, bus.out2_ready, bus.out1_ready};

`ifdef STREAM_DEMUX4_RR_EN
  dest_t rr_ptr;

  assign dest = bus.in_rr ? rr_ptr : bus.in_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && bus.in_rr) begin
      rr_ptr <= rr_next(rr_ptr);
    end
  end
`else
  assign dest = bus.in_sel;
`endif

  // Ready is independent of in_valid so producers may wait on it before asserting valid.
  assign bus.in_ready = ~slot_vld[dest] | out_rdy[dest];
  assign accept       = bus.in_valid & bus.in_ready;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (accept && (dest == dest_t'(i))),
      .load_data  (bus.in_data),
      .drain      (slot_vld[i] & out_rdy[i]),
      .slot_valid (slot_vld[i]),
      .slot_data  (slot_dat[i])
    );
  end

  assign bus.out1_valid = slot_vld[0];
  assign bus.out2_valid = slot_vld[1];
  assign bus.out3_valid = slot_vld[2];
  assign bus.out4_valid = slot_vld[3];
  assign bus.out1_data  = slot_dat[0];
  assign bus.out2_data  = slot_dat[1];
  assign bus.out3_data  = slot_dat[2];
  assign bus.out4_data  = slot_dat[3];
endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4 (WIDTH=8) with a per-channel scoreboard; covers round-robin when STREAM_DEMUX4_RR_EN is defined.
module tb_stream_demux4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stream_demux4_if #(.WIDTH(8)) bus ();

  stream_demux4 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] ordy;
  logic [3:0] ov;
  logic [7:0] od [4];
  logic [7:0] exp_q [4][$];

  assign bus.out1_ready = ordy[0];
  assign bus.out2_ready = ordy[1];
  assign bus.out3_ready = ordy[2];
  assign bus.out4_ready = ordy[3];
  assign ov    = {bus.out4_valid, bus.out3_valid, bus.out2_valid, bus.out1_valid};
  assign od[0] = bus.out1_data;
  assign od[1] = bus.out2_data;
  assign od[2] = bus.out3_data;
  assign od[3] = bus.out4_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every drain must match the oldest expected word of that channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) begin
        if (ov[c] === 1'b1 && ordy[c] === 1'b1) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("unexpected_out%0d", c + 1), {24'd0, od[c]}, 32'hFFFF_FFFF);
          end else begin
            check($sformatf("sb_out%0d", c + 1), {24'd0, od[c]}, {24'd0, exp_q[c].pop_front()});
          end
        end
      end
    end
  end

  // Called just after a rising edge; leaves time just after the next rising edge.
  task automatic send(input logic [7:0] d, input logic [1:0] sel, input int ch, input logic exp_rdy);
    bus.in_data  = d;
    bus.in_sel   = sel;
    bus.in_valid = 1'b1;
    #1;
    check($sformatf("in_ready_%0h", d), {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) exp_q[ch].push_back(d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (exp_rdy) begin
      check($sformatf("lat_valid_%0h", d), {31'd0, ov[ch]}, 32'd1);
      check($sformatf("lat_data_%0h", d), {24'd0, od[ch]}, {24'd0, d});
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_data  = 8'hEE;
    bus.in_sel   = 2'd0;
    bus.in_valid = 1'b1;
`ifdef STREAM_DEMUX4_RR_EN
    bus.in_rr    = 1'b0;
`endif
    ordy = 4'b1111;

    // 1. reset with in_valid high
    tick(2);
    check("rst_valid", {28'd0, ov}, 32'd0);
    for (int c = 0; c < 4; c++) check($sformatf("rst_data%0d", c + 1), {24'd0, od[c]}, 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick(1);
    check("post_rst_valid", {28'd0, ov}, 32'd0);

    // 2. routing at full rate
    send(8'hA1, 2'd0, 0, 1'b1);
    send(8'hB2, 2'd1, 1, 1'b1);
    send(8'hC3, 2'd2, 2, 1'b1);
    send(8'hD4, 2'd3, 3, 1'b1);
    tick(2);

    // 3. backpressure on out2, then drain and refill on one edge
    ordy[1] = 1'b0;
    send(8'h11, 2'd1, 1, 1'b1);
    bus.in_data  = 8'h22;
    bus.in_sel   = 2'd1;
    bus.in_valid = 1'b1;
    #1;
    check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick(1);
    check("bp_hold_valid", {31'd0, ov[1]}, 32'd1);
    check("bp_hold_data", {24'd0, od[1]}, 32'h11);
    ordy[1] = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    exp_q[1].push_back(8'h22);
    tick(1);
    bus.in_valid = 1'b0;
    check("bp_refill_data", {24'd0, od[1]}, 32'h22);
    check("bp_refill_valid", {31'd0, ov[1]}, 32'd1);
    tick(2);

    // 4. independence: out3 stalled, out1 still flows
    ordy[2] = 1'b0;
    send(8'h33, 2'd2, 2, 1'b1);
    send(8'h55, 2'd0, 0, 1'b1);
    check("ind_out3_valid", {31'd0, ov[2]}, 32'd1);
    check("ind_out3_data", {24'd0, od[2]}, 32'h33);
    bus.in_sel = 2'd2;
    #1;
    check("ind_sel2_ready", {31'd0, bus.in_ready}, 32'd0);
    ordy[2] = 1'b1;
    tick(2);

    // 5. reset discards stalled words
    ordy[0] = 1'b0;
    ordy[3] = 1'b0;
    send(8'h77, 2'd0, 0, 1'b1);
    send(8'h88, 2'd3, 3, 1'b1);
    rst = 1'b1;
    exp_q[0].delete();
    exp_q[3].delete();
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", {28'd0, ov}, 32'd0);
    ordy = 4'b1111;
    send(8'h99, 2'd3, 3, 1'b1);
    tick(2);

`ifdef STREAM_DEMUX4_RR_EN
    // 6. round-robin ignores in_sel; pointer restarts at 0 after reset
    bus.in_rr = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(i), 2'd3, i % 4, 1'b1);
    bus.in_rr = 1'b0;
    send(8'h40, 2'd2, 2, 1'b1);
    bus.in_rr = 1'b1;
    send(8'h41, 2'd0, 2, 1'b1);
    bus.in_rr = 1'b0;
    tick(2);
`endif

    tick(3);
    for (int c = 0; c < 4; c++) check($sformatf("sb_left_out%0d", c + 1), exp_q[c].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
